debug_state_loader: RTL and testbench

DEBUG_STATE_LOADER -- requirements
Module: debug_state_loader

---
 rtl/debug_state_loader.sv | 142 ++++++++++++++
 tb/tb_debug_state_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_state_loader.sv
// debug_state_loader
//   Debug-port loader that pushes register-file and data-RAM contents into a
//   processor while holding it stalled. A session opens on start, accepts a
//   stream of write commands (one per two cycles), and closes after the
//   command flagged last, keeping the CPU held for RELEASE_CYCLES more cycles.
//
// Ports
//   Clk, reset               clock, synchronous active-high reset
//   start                    one-cycle session request (honoured only in IDLE)
//   cmd_valid / cmd_ready    command handshake
//   cmd_target               0 = register file, 1 = data RAM
//   cmd_addr, cmd_data       write address / data
//   cmd_last                 final command of the session
//   rf_we/rf_waddr/rf_wdata  register-file write port (registered)
//   mem_we/mem_addr/mem_wdata data-RAM write port (registered)
//   cpu_hold                 processor held while the loader owns the state
//   busy, done, err          status; done is a one-cycle pulse, err is sticky
//   wr_count                 writes performed in the current / last session
module debug_state_loader #(
  parameter int MEM_AW         = 10,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_target,
  input  logic [MEM_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_last,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, RELEASE} state_t;

  // Counter sized so RELEASE_CYCLES itself fits, and never zero width.
  localparam int CW = $clog2(RELEASE_CYCLES + 2);

  state_t        state, state_nxt;
  logic [CW-1:0] rel_cnt;
  logic          last_q;
  logic          handshake;
  logic [31:0]   addr_ext;
  logic          rf_addr_ok;

  assign handshake  = (state == ACCEPT) && cmd_valid;
  // Register index must be 1..31: x0 is hardwired and anything above 31 is
  // outside the register file.
  assign addr_ext   = 32'(cmd_addr);
  assign rf_addr_ok = (addr_ext[31:5] == '0) && (addr_ext[4:0] != 5'd0);

  // State register
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCEPT;
      ACCEPT:  if (cmd_valid) state_nxt = WRITE;
      WRITE: begin
        if (!last_q)                  state_nxt = ACCEPT;
        else if (RELEASE_CYCLES == 0) state_nxt = IDLE;
        else                          state_nxt = RELEASE;
      end
      RELEASE: if (rel_cnt <= CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready = (state == ACCEPT);
    busy      = (state != IDLE);
    cpu_hold  = (state != IDLE);
  end

  // Datapath: write ports, counters and status flags
  always_ff @(posedge Clk) begin
    if (reset) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_count  <= '0;
      last_q    <= 1'b0;
      rel_cnt   <= '0;
    end else begin
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
      // Pulse on the transition into IDLE; reset clears it so an aborted
      // session never reports done.
      done   <= (state != IDLE) && (state_nxt == IDLE);

      if (state == IDLE && start) begin
        err      <= 1'b0;
        wr_count <= '0;
      end

      // Strobe is registered at the handshake edge, so it is high exactly
      // during the single WRITE cycle.
      if (handshake) begin
        last_q <= cmd_last;
        if (cmd_target) begin
          mem_we    <= 1'b1;
          mem_addr  <= cmd_addr;
          mem_wdata <= cmd_data;
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else if (rf_addr_ok) begin
          rf_we    <= 1'b1;
          rf_waddr <= addr_ext[4:0];
          rf_wdata <= cmd_data;
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          err <= 1'b1;
        end
      end

      if (state == WRITE && last_q) rel_cnt <= CW'(RELEASE_CYCLES);
      else if (state == RELEASE)    rel_cnt <= rel_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_debug_state_loader.sv
module tb_debug_state_loader;

  logic        Clk = 1'b0;
  logic        reset, start, cmd_valid, cmd_target, cmd_last;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_ready, rf_we, mem_we, cpu_hold, busy, done, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, mem_wdata;
  logic [9:0]  mem_addr;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  debug_state_loader #(.MEM_AW(10), .RELEASE_CYCLES(2)) dut (
    .Clk(Clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .wr_count(wr_count)
  );

  task automatic send(input logic tgt, input logic [9:0] a,
                      input logic [31:0] d, input logic lst);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_addr   = a;
    cmd_data   = d;
    cmd_last   = lst;
  endtask

  // Bounded wait for the done pulse; afterwards the CPU must be released.
  task automatic wait_done(input string name);
    bit got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge Clk);
      if (done === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s done: not seen within 6 cycles", name);
    end
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++; $display("FAIL %s cpu_hold after done: got %b want 0", name, cpu_hold);
    end
  endtask

  task automatic test_reset;
    reset = 1; start = 1; send(1, 10'h3FF, 32'hFFFFFFFF, 1);
    @(negedge Clk); @(negedge Clk);
    checks++; if ({cpu_hold, busy, done, err} !== 4'b0) begin
      errors++; $display("FAIL reset status: got %b want 0000", {cpu_hold, busy, done, err}); end
    checks++; if ({rf_we, mem_we, cmd_ready} !== 3'b0) begin
      errors++; $display("FAIL reset strobes: got %b want 000", {rf_we, mem_we, cmd_ready}); end
    checks++; if (wr_count !== 16'd0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 ||
                  mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset regs: cnt %h ra %h rd %h ma %h md %h want all 0",
                         wr_count, rf_waddr, rf_wdata, mem_addr, mem_wdata); end
    reset = 0; start = 0; cmd_valid = 0;
    @(negedge Clk);
  endtask

  task automatic test_basic;
    start = 1;
    @(negedge Clk);
    start = 0;
    checks++; if ({cmd_ready, cpu_hold, busy} !== 3'b111 || wr_count !== 16'd0) begin
      errors++; $display("FAIL basic accept: rdy/hold/busy %b cnt %0d want 111/0",
                         {cmd_ready, cpu_hold, busy}, wr_count); end
    send(0, 10'd5, 32'hDEADBEEF, 0);
    @(negedge Clk);
    checks++; if (rf_we !== 1'b1 || mem_we !== 1'b0 || rf_waddr !== 5'd5 ||
                  rf_wdata !== 32'hDEADBEEF || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL basic rf write: we %b/%b a %0d d %h rdy %b want 1/0 5 deadbeef 0",
                         rf_we, mem_we, rf_waddr, rf_wdata, cmd_ready); end
    send(1, 10'd3, 32'h12345678, 1);
    @(negedge Clk);
    checks++; if (rf_we !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL basic reaccept: rf_we %b rdy %b want 0 1", rf_we, cmd_ready); end
    @(negedge Clk);
    checks++; if (mem_we !== 1'b1 || rf_we !== 1'b0 || mem_addr !== 10'd3 ||
                  mem_wdata !== 32'h12345678 || wr_count !== 16'd2) begin
      errors++; $display("FAIL basic mem write: we %b/%b a %0d d %h cnt %0d want 1/0 3 12345678 2",
                         mem_we, rf_we, mem_addr, mem_wdata, wr_count); end
    cmd_valid = 0;
    @(negedge Clk);
    checks++; if ({cpu_hold, busy, done, mem_we, cmd_ready} !== 5'b11000) begin
      errors++; $display("FAIL basic release1: got %b want 11000",
                         {cpu_hold, busy, done, mem_we, cmd_ready}); end
    @(negedge Clk);
    checks++; if ({cpu_hold, done} !== 2'b10) begin
      errors++; $display("FAIL basic release2: hold/done %b want 10", {cpu_hold, done}); end
    @(negedge Clk);
    checks++; if ({done, cpu_hold, busy} !== 3'b100 || wr_count !== 16'd2) begin
      errors++; $display("FAIL basic done: done/hold/busy %b cnt %0d want 100 2",
                         {done, cpu_hold, busy}, wr_count); end
    checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || mem_addr !== 10'd3) begin
      errors++; $display("FAIL basic hold regs: ra %0d rd %h ma %0d want 5 deadbeef 3",
                         rf_waddr, rf_wdata, mem_addr); end
    @(negedge Clk);
    checks++; if (done !== 1'b0) begin
      errors++; $display("FAIL basic done width: done %b want 0", done); end
  endtask

  task automatic test_reject;
    start = 1;
    @(negedge Clk);
    start = 0;
    send(0, 10'd0, 32'hFFFFFFFF, 1);
    @(negedge Clk);
    cmd_valid = 0;
    checks++; if (rf_we !== 1'b0 || mem_we !== 1'b0 || err !== 1'b1 || wr_count !== 16'd0) begin
      errors++; $display("FAIL reject x0: we %b/%b err %b cnt %0d want 0/0 1 0",
                         rf_we, mem_we, err, wr_count); end
    wait_done("reject");
    checks++; if (err !== 1'b1) begin
      errors++; $display("FAIL reject sticky err: got %b want 1", err); end
  endtask

  task automatic test_rf_bounds;
    start = 1;
    @(negedge Clk);
    start = 0;
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL bounds err clear on start: got %b want 0", err); end
    send(0, 10'd33, 32'h0000_1111, 0);
    @(negedge Clk);
    cmd_valid = 0;
    checks++; if (rf_we !== 1'b0 || err !== 1'b1 || wr_count !== 16'd0) begin
      errors++; $display("FAIL bounds addr33: we %b err %b cnt %0d want 0 1 0", rf_we, err, wr_count); end
    @(negedge Clk);
    send(0, 10'd31, 32'h0BADF00D, 1);
    @(negedge Clk);
    cmd_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h0BADF00D ||
                  wr_count !== 16'd1) begin
      errors++; $display("FAIL bounds addr31: we %b a %0d d %h cnt %0d want 1 31 0badf00d 1",
                         rf_we, rf_waddr, rf_wdata, wr_count); end
    wait_done("bounds");
  endtask

  task automatic test_back_to_back;
    int strobes = 0;
    start = 1;
    @(negedge Clk);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_ready !== 1'b1) begin
        errors++; $display("FAIL b2b ready[%0d]: got %b want 1", i, cmd_ready); end
      send(1'(i % 2), 10'(10 + i), 32'hC0DE_0000 + 32'(i), (i == 3));
      @(negedge Clk);
      strobes += int'(rf_we) + int'(mem_we);
      checks++; if (cmd_ready !== 1'b0 || (rf_we + mem_we) !== 2'd1 || mem_we !== 1'(i % 2)) begin
        errors++; $display("FAIL b2b write[%0d]: rdy %b rf %b mem %b want 0 one strobe mem=%0d",
                           i, cmd_ready, rf_we, mem_we, i % 2); end
      if (i == 3) cmd_valid = 0;
      @(negedge Clk);
      strobes += int'(rf_we) + int'(mem_we);
    end
    checks++; if (strobes != 4 || wr_count !== 16'd4) begin
      errors++; $display("FAIL b2b totals: strobes %0d cnt %0d want 4 4", strobes, wr_count); end
    wait_done("b2b");
  endtask

  task automatic test_reset_mid;
    start = 1;
    @(negedge Clk);
    start = 0;
    send(1, 10'd7, 32'hCAFEF00D, 0);
    @(negedge Clk);
    checks++; if (mem_we !== 1'b1) begin
      errors++; $display("FAIL midrst pre: mem_we %b want 1", mem_we); end
    reset = 1; cmd_valid = 0;
    @(negedge Clk);
    checks++; if ({mem_we, cpu_hold, busy, done} !== 4'b0 || mem_addr !== 10'd0) begin
      errors++; $display("FAIL midrst abort: we/hold/busy/done %b ma %0d want 0000 0",
                         {mem_we, cpu_hold, busy, done}, mem_addr); end
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++; if ({done, mem_we, rf_we, busy} !== 4'b0) begin
        errors++; $display("FAIL midrst quiet[%0d]: done/mem/rf/busy %b want 0000",
                           k, {done, mem_we, rf_we, busy}); end
    end
    start = 1;
    @(negedge Clk);
    start = 0;
    send(0, 10'd2, 32'h2222_2222, 1);
    @(negedge Clk);
    cmd_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || wr_count !== 16'd1) begin
      errors++; $display("FAIL midrst restart: we %b a %0d cnt %0d want 1 2 1",
                         rf_we, rf_waddr, wr_count); end
    wait_done("midrst");
  endtask

  task automatic test_start_busy;
    start = 1;
    @(negedge Clk);
    start = 0;
    send(0, 10'd1, 32'h1111_1111, 0);
    @(negedge Clk);
    cmd_valid = 0;
    @(negedge Clk);
    start = 1;
    @(negedge Clk);
    start = 0;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b1 || wr_count !== 16'd1) begin
      errors++; $display("FAIL startbusy: rdy %b busy %b cnt %0d want 1 1 1",
                         cmd_ready, busy, wr_count); end
    send(1, 10'd4, 32'h4444_4444, 1);
    @(negedge Clk);
    cmd_valid = 0;
    checks++; if (mem_we !== 1'b1 || wr_count !== 16'd2) begin
      errors++; $display("FAIL startbusy write: we %b cnt %0d want 1 2", mem_we, wr_count); end
    wait_done("startbusy");
  endtask

  task automatic test_ram_top;
    start = 1;
    @(negedge Clk);
    start = 0;
    send(1, 10'd1023, 32'hA5A5A5A5, 1);
    @(negedge Clk);
    cmd_valid = 0;
    checks++; if (mem_we !== 1'b1 || rf_we !== 1'b0 || mem_addr !== 10'd1023 ||
                  mem_wdata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL ramtop: we %b/%b a %0d d %h want 1/0 1023 a5a5a5a5",
                         mem_we, rf_we, mem_addr, mem_wdata); end
    wait_done("ramtop");
  endtask

  initial begin
    reset = 1; start = 0; cmd_valid = 0; cmd_target = 0;
    cmd_addr = '0; cmd_data = '0; cmd_last = 0;
    test_reset;
    test_basic;
    test_reject;
    test_rf_bounds;
    test_back_to_back;
    test_reset_mid;
    test_start_busy;
    test_ram_top;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
